// File: rtl/mem_line_master_if.sv
// ============================================================================
// Module      : mem_line_master_if
// Description : Request/response and RAM-strobe bundle for mem_line_master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_line_master_if #(
    parameter int WORDS_PER_LINE = 4
);
    logic                          req_valid;
    logic                          req_ready;
    logic                          req_write;
    logic [31:0]                   req_addr;
    logic [32*WORDS_PER_LINE-1:0]  req_wdata;
    logic                          rsp_valid;
    logic [32*WORDS_PER_LINE-1:0]  rsp_rdata;
    logic                          rsp_err;
    logic [31:0]                   mem_addr;
    logic                          mem_ce_n;
    logic                          mem_oe_n;
    logic                          mem_we_n;
    logic                          mem_bw;
    logic                          mem_hold_i;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_hold_i,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_bw
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_hold_i,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_ce_n, mem_oe_n, mem_we_n, mem_bw
    );
endinterface

`default_nettype wire

// File: rtl/mem_line_master.sv
// ============================================================================
// Module      : mem_line_master
// Description : Line-burst engine driving an async-SRAM-style RAM (read/write
//               one cache line word by word). Optional macro MEM_TIMEOUT_EN
//               aborts a burst after TIMEOUT_CYCLES consecutive hold cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_line_master #(
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    mem_line_master_if.master bus,
    inout  wire [31:0]        mem_data
);
    localparam int IDXW = $clog2(WORDS_PER_LINE);
    localparam int OFF  = $clog2(4 * WORDS_PER_LINE);
    localparam logic [IDXW-1:0] C_LAST = IDXW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                             state_q;
    logic                               ready_q;
    logic                               rsp_valid_q;
    logic [IDXW-1:0]                    idx_q;
    logic [31:0]                        addr_q;
    logic [31:0]                        wdout_q;
    logic                               ce_n_q;
    logic                               oe_n_q;
    logic                               we_n_q;
    logic                               bw_q;
    logic [WORDS_PER_LINE-1:0][31:0]    wline_q;
    logic [WORDS_PER_LINE-1:0][31:0]    rdata_q;
    logic                               w_unused_addr;

    assign w_unused_addr = ^bus.req_addr[OFF-1:0];

`ifdef MEM_TIMEOUT_EN
    localparam int HCW = $clog2(TIMEOUT_CYCLES + 1);
    logic [HCW-1:0] hold_cnt_q;
    logic           rsp_err_q;
    assign bus.rsp_err = rsp_err_q;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYCLES;
    assign bus.rsp_err      = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            idx_q       <= '0;
            addr_q      <= '0;
            wdout_q     <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            bw_q        <= 1'b0;
            wline_q     <= '0;
            rdata_q     <= '0;
`ifdef MEM_TIMEOUT_EN
            hold_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        idx_q   <= '0;
                        addr_q  <= {bus.req_addr[31:OFF], {OFF{1'b0}}};
                        rdata_q <= '0;
                        ce_n_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
                        hold_cnt_q <= '0;
                        rsp_err_q  <= 1'b0;
`endif
                        if (bus.req_write) begin
                            we_n_q  <= 1'b0;
                            bw_q    <= 1'b1;
                            wline_q <= bus.req_wdata;
                            wdout_q <= bus.req_wdata[31:0];
                            state_q <= S_WRITE;
                        end else begin
                            oe_n_q  <= 1'b0;
                            state_q <= S_READ;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                S_READ, S_WRITE: begin
                    if (!bus.mem_hold_i) begin
                        if (state_q == S_READ) begin
                            rdata_q[idx_q] <= mem_data;
                        end
`ifdef MEM_TIMEOUT_EN
                        hold_cnt_q <= '0;
`endif
                        if (idx_q == C_LAST) begin
                            ce_n_q      <= 1'b1;
                            oe_n_q      <= 1'b1;
                            we_n_q      <= 1'b1;
                            bw_q        <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            addr_q  <= addr_q + 32'd4;
                            wdout_q <= wline_q[idx_q + 1'b1];
                        end
                    end
`ifdef MEM_TIMEOUT_EN
                    // This hold edge is the TIMEOUT_CYCLES-th in a row: abandon the burst.
                    else if (hold_cnt_q == HCW'(TIMEOUT_CYCLES - 1)) begin
                        ce_n_q      <= 1'b1;
                        oe_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                        bw_q        <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Only the write strobe enables the data driver, so the bus is released between bursts.
    assign mem_data      = we_n_q ? {32{1'bz}} : wdout_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_ce_n  = ce_n_q;
    assign bus.mem_oe_n  = oe_n_q;
    assign bus.mem_we_n  = we_n_q;
    assign bus.mem_bw    = bw_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_line_master.sv
// ============================================================================
// Module      : tb_mem_line_master
// Description : Directed self-checking bench for mem_line_master with a small RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_line_master;
    localparam int W  = 4;
    localparam int TO = 8;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    mem_line_master_if #(.WORDS_PER_LINE(W)) bus();
    wire [31:0] mem_data;

    logic [31:0] init_ram [0:63];
    logic [31:0] wram     [0:63];
    logic [63:0] wvalid = '0;
    logic [5:0]  ridx;

    assign ridx     = bus.mem_addr[7:2];
    assign mem_data = (!bus.mem_ce_n && !bus.mem_oe_n) ?
                      (wvalid[ridx] ? wram[ridx] : init_ram[ridx]) : 32'bz;

    always @(posedge clk) begin
        if (!bus.mem_ce_n && !bus.mem_we_n && !bus.mem_hold_i) begin
            wram[ridx]   <= mem_data;
            wvalid[ridx] <= 1'b1;
        end
    end

    mem_line_master #(.WORDS_PER_LINE(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.rsp_valid, bus.rsp_err, bus.req_ready} !== 3'b000) begin
            errors++; $display("FAIL reset_rsp: got %b expected 000", {bus.rsp_valid, bus.rsp_err, bus.req_ready});
        end
        checks++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_bw} !== 4'b1110) begin
            errors++; $display("FAIL reset_strobes: got %b expected 1110", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_bw});
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.rsp_rdata !== 128'h0) begin
            errors++; $display("FAIL reset_addr_rdata: got %h / %h expected 0", bus.mem_addr, bus.rsp_rdata);
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b expected 1", bus.req_ready);
        end
    endtask

    task automatic test_read();
        logic [127:0] exp;
        exp = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        @(negedge clk); bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10010000;
        @(negedge clk); bus.req_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.mem_addr !== 32'h10010000 + 32'(4*i) || {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b001) begin
                errors++; $display("FAIL read_word%0d: got addr %h strobes %b expected %h 001", i, bus.mem_addr,
                                   {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n}, 32'h10010000 + 32'(4*i));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== exp) begin
            errors++; $display("FAIL read_rsp: got v=%b e=%b %h expected v=1 e=0 %h", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, exp);
        end
        checks++;
        if ({bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n} !== 3'b111) begin
            errors++; $display("FAIL read_strobes_off: got %b expected 111", {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n});
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++; $display("FAIL read_after_rsp: got v=%b rdy=%b expected v=0 rdy=1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_write();
        logic [127:0] d;
        d = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
        @(negedge clk); bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10010013; bus.req_wdata = d;
        @(negedge clk); bus.req_valid = 1'b0; bus.req_wdata = '0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.mem_addr !== 32'h10010010 + 32'(4*i) || mem_data !== d[32*i +: 32] ||
                {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_bw} !== 4'b0101) begin
                errors++; $display("FAIL write_word%0d: got addr %h data %h strobes %b expected %h %h 0101", i, bus.mem_addr,
                                   mem_data, {bus.mem_ce_n, bus.mem_oe_n, bus.mem_we_n, bus.mem_bw},
                                   32'h10010010 + 32'(4*i), d[32*i +: 32]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || {bus.mem_ce_n, bus.mem_we_n, bus.mem_bw} !== 3'b110) begin
            errors++; $display("FAIL write_rsp: got v=%b strobes %b expected v=1 110", bus.rsp_valid,
                               {bus.mem_ce_n, bus.mem_we_n, bus.mem_bw});
        end
        for (int i = 0; i < W; i++) begin
            checks++;
            if (wvalid[4+i] !== 1'b1 || wram[4+i] !== d[32*i +: 32]) begin
                errors++; $display("FAIL write_ram%0d: got %b/%h expected 1/%h", i, wvalid[4+i], wram[4+i], d[32*i +: 32]);
            end
        end
        @(negedge clk); bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10010010;
        @(negedge clk); bus.req_valid = 1'b0;
        repeat (W) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== d) begin
            errors++; $display("FAIL write_readback: got v=%b %h expected v=1 %h", bus.rsp_valid, bus.rsp_rdata, d);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        logic [127:0] exp;
        exp = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        @(negedge clk); bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10010000; bus.mem_hold_i = 1'b1;
        @(negedge clk); bus.req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (bus.mem_addr !== 32'h10010000 || bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL hold_cycle%0d: got addr %h v=%b expected 10010000 v=0", k, bus.mem_addr, bus.rsp_valid);
            end
            if (k < 3) @(negedge clk);
        end
        bus.mem_hold_i = 1'b0;
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_addr !== 32'h10010000 + 32'(4*i) || bus.rsp_valid !== 1'b0) begin
                errors++; $display("FAIL hold_word%0d: got addr %h v=%b expected %h v=0", i, bus.mem_addr, bus.rsp_valid,
                                   32'h10010000 + 32'(4*i));
            end
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp) begin
            errors++; $display("FAIL hold_rsp: got v=%b %h expected v=1 %h", bus.rsp_valid, bus.rsp_rdata, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midburst();
        logic [127:0] exp;
        exp = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        @(negedge clk); bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 32'h10010020;
        bus.req_wdata = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        @(negedge clk); bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.mem_addr !== 32'h10010028 || bus.mem_we_n !== 1'b0) begin
            errors++; $display("FAIL rstmid_word2: got addr %h we_n=%b expected 10010028 0", bus.mem_addr, bus.mem_we_n);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n, bus.req_ready} !== 4'b1110) begin
            errors++; $display("FAIL rstmid_async: got %b expected 1110", {bus.mem_ce_n, bus.mem_we_n, bus.mem_oe_n, bus.req_ready});
        end
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_release: got rdy=%b v=%b expected rdy=1 v=0", bus.req_ready, bus.rsp_valid);
        end
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10010004;
        @(negedge clk); bus.req_valid = 1'b0;
        repeat (W) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp) begin
            errors++; $display("FAIL rstmid_fresh_read: got v=%b %h expected v=1 %h", bus.rsp_valid, bus.rsp_rdata, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [127:0] exp;
        exp = {init_ram[63], init_ram[62], init_ram[61], init_ram[60]};
        @(negedge clk); bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'hFFFFFFF0;
        @(negedge clk); bus.req_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            checks++;
            if (bus.mem_addr !== 32'hFFFFFFF0 + 32'(4*i)) begin
                errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, bus.mem_addr, 32'hFFFFFFF0 + 32'(4*i));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp) begin
            errors++; $display("FAIL wrap_rsp: got v=%b %h expected v=1 %h", bus.rsp_valid, bus.rsp_rdata, exp);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int           first;
        logic         err_seen;
        logic [127:0] rd;
        first = 0; err_seen = 1'b0; rd = '0;
        @(negedge clk); bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h10010000; bus.mem_hold_i = 1'b1;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            if (bus.rsp_valid === 1'b1 && first == 0) begin
                first = n; err_seen = bus.rsp_err; rd = bus.rsp_rdata;
            end
        end
`ifdef MEM_TIMEOUT_EN
        checks++;
        if (first != TO + 1 || err_seen !== 1'b1 || rd !== 128'h0) begin
            errors++; $display("FAIL timeout_rsp: got cycle %0d err=%b %h expected cycle %0d err=1 0", first, err_seen, rd, TO + 1);
        end
        bus.mem_hold_i = 1'b0;
`else
        checks++;
        if (first != 0 || bus.mem_ce_n !== 1'b0) begin
            errors++; $display("FAIL no_timeout: got rsp cycle %0d ce_n=%b expected 0 0", first, bus.mem_ce_n);
        end
        reset_n = 1'b0;
        @(negedge clk); reset_n = 1'b1; bus.mem_hold_i = 1'b0;
`endif
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.mem_ce_n !== 1'b1) begin
            errors++; $display("FAIL timeout_recover: got rdy=%b ce_n=%b expected 1 1", bus.req_ready, bus.mem_ce_n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            init_ram[i] = (i < 4) ? 32'h11111111 * 32'(i + 1) : 32'hC0DE0000 + 32'(i);
        end
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.mem_hold_i = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_hold();
        test_reset_midburst();
        test_wrap();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
